// File: rtl/snoop_pingpong_mem.sv
// Ping-pong packet buffer between dataval_snooper and the BPF CPU read port.
// One bank fills while the other is read; packets are handed over in fill order.
module snoop_pingpong_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  done,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_pkt_valid,
  output logic [ADDR_WIDTH:0]   rd_pkt_len,
  input  logic                  rd_done,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    READY
  } bank_st_e;

  bank_st_e              st_q [2];
  bank_st_e              st_d [2];
  logic [LW-1:0]         len_q [2];
  logic [LW-1:0]         len_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LW-1:0]         trk_q, trk_d;
  logic                  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic          wr_ok;
  logic          wr_rej;
  logic          drop_now;
  logic          handoff;
  logic          release_pkt;
  logic [LW-1:0] wr_end;
  logic [LW-1:0] trk_nxt;

  assign mem_ready    = (st_q[wr_bank_q] != READY);
  assign rd_pkt_valid = (st_q[rd_bank_q] == READY);
  assign rd_pkt_len   = len_q[rd_bank_q];
  assign rd_data      = rd_data_q;
  assign drop_cnt     = drop_cnt_q;

  assign wr_ok       = wr_en && mem_ready;
  assign wr_rej      = wr_en && !mem_ready;
  // A packet that lost any word is dropped, even if a bank has freed since
  assign drop_now    = done && (drop_q || wr_rej);
  assign wr_end      = LW'(wr_addr) + LW'(1);
  assign trk_nxt     = (wr_ok && (wr_end > trk_q)) ? wr_end : trk_q;
  assign handoff     = done && mem_ready && !drop_now
                       && (trk_nxt != '0);
  assign release_pkt = rd_done && rd_pkt_valid;

  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    trk_d      = trk_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    rd_data_d  = rd_en ? mem_q[rd_bank_q][rd_addr] : rd_data_q;

    if (wr_ok && (st_q[wr_bank_q] == EMPTY)) begin
      st_d[wr_bank_q] = FILLING;
    end

    unique case (1'b1)
      drop_now: begin
        drop_d = 1'b0;
        trk_d  = '0;
        if (!(&drop_cnt_q)) begin
          drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
        if (st_q[wr_bank_q] != READY) begin
          st_d[wr_bank_q] = EMPTY;
        end
      end
      handoff: begin
        st_d[wr_bank_q]  = READY;
        len_d[wr_bank_q] = trk_nxt;
        wr_bank_d        = ~wr_bank_q;
        trk_d            = '0;
      end
      default: begin
        trk_d = trk_nxt;
        if (wr_rej) begin
          drop_d = 1'b1;
        end
      end
    endcase

    if (release_pkt) begin
      st_d[rd_bank_q] = EMPTY;
      rd_bank_d       = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      trk_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      trk_q      <= trk_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_bank_q][wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_snoop_pingpong_mem.sv
// Bench for snoop_pingpong_mem: vector table, corner sequences and random
// traffic against a packet-queue reference model.
module tb_snoop_pingpong_mem;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DEP  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          done;
  logic          mem_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_pkt_valid;
  logic [AW:0]   rd_pkt_len;
  logic          rd_done;
  logic [CW-1:0] drop_cnt;

  snoop_pingpong_mem #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .done        (done),
    .mem_ready   (mem_ready),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_pkt_valid(rd_pkt_valid),
    .rd_pkt_len  (rd_pkt_len),
    .rd_done     (rd_done),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  function void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: FIFO of completed packets plus a fill cursor
  typedef struct {
    int bank;
    int len;
  } pkt_t;

  pkt_t          rq[$];
  logic [DW-1:0] mmem [2][DEP];
  bit            mval [2][DEP];
  int            fb;
  int            cur;
  bit            dflag;
  int            cnt;
  logic [DW-1:0] exp_rd;
  bit            rd_known;

  function void mdl_reset();
    rq.delete();
    fb       = 0;
    cur      = 0;
    dflag    = 0;
    cnt      = 0;
    exp_rd   = '0;
    rd_known = 1;
  endfunction

  function void mdl_step(bit we, int wa, logic [DW-1:0] wd,
                         bit dn, bit re, int ra, bit rdn);
    bit mr, acc, rej, dropnow, pop;
    int nl;
    mr      = rq.size() < 2;
    acc     = we && mr;
    rej     = we && !mr;
    dropnow = dn && (dflag || rej);
    nl      = cur;
    if (acc && (wa + 1 > nl)) nl = wa + 1;
    if (re) begin
      if (rq.size() > 0 && mval[rq[0].bank][ra]) begin
        exp_rd   = mmem[rq[0].bank][ra];
        rd_known = 1;
      end else begin
        rd_known = 0;
      end
    end
    pop = rdn && (rq.size() > 0);
    if (acc) begin
      mmem[fb][wa] = wd;
      mval[fb][wa] = 1;
    end
    if (dropnow) begin
      if (cnt < CMAX) cnt++;
      dflag = 0;
      cur   = 0;
    end else if (dn && mr && nl != 0) begin
      rq.push_back(pkt_t'{bank: fb, len: nl});
      fb  = fb ^ 1;
      cur = 0;
    end else begin
      cur = nl;
      if (rej) dflag = 1;
    end
    if (pop) void'(rq.pop_front());
  endfunction

  function void mdl_check(string tag);
    chk({tag, "_mem_ready"}, 64'(mem_ready), 64'(rq.size() < 2));
    chk({tag, "_valid"}, 64'(rd_pkt_valid), 64'(rq.size() > 0));
    if (rq.size() > 0)
      chk({tag, "_len"}, 64'(rd_pkt_len), 64'(rq[0].len));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(cnt));
    if (rd_known)
      chk({tag, "_rd_data"}, 64'(rd_data), 64'(exp_rd));
  endfunction

  task automatic step(string tag, bit we, int wa, logic [DW-1:0] wd,
                      bit dn, bit re, int ra, bit rdn);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    done    = dn;
    rd_en   = re;
    rd_addr = AW'(ra);
    rd_done = rdn;
    @(posedge clk);
    #1;
    mdl_step(we, wa, wd, dn, re, ra, rdn);
    mdl_check(tag);
  endtask

  task automatic idle_inputs();
    wr_en   = 0;
    wr_addr = '0;
    wr_data = '0;
    done    = 0;
    rd_en   = 0;
    rd_addr = '0;
    rd_done = 0;
  endtask

  task automatic do_reset(string tag);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    mdl_reset();
    chk({tag, "_rst_mem_ready"}, 64'(mem_ready), 64'd1);
    chk({tag, "_rst_valid"}, 64'(rd_pkt_valid), 64'd0);
    chk({tag, "_rst_len"}, 64'(rd_pkt_len), 64'd0);
    chk({tag, "_rst_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_rst_drop"}, 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int we, wa, wd, dn, re, ra, rdn;
    int mr, v, len, rdc, rd, drop;
  } vec_t;

  function automatic vec_t mk(int we, int wa, int wd, int dn,
                              int re, int ra, int rdn, int mr,
                              int v, int len, int rdc, int rd,
                              int drop);
    vec_t t;
    t = '{we, wa, wd, dn, re, ra, rdn, mr, v, len, rdc, rd, drop};
    return t;
  endfunction

  localparam int NV = 14;
  vec_t vec [NV];

  initial begin
    int r_we, r_wa, r_dn, r_re, r_ra, r_rdn;
    errs   = 0;
    checks = 0;
    idle_inputs();
    rst_n = 1'b0;

    //          we wa  wd   dn re ra rdn mr v len rdc rd   drop
    vec[0]  = mk(1, 0, 'hA0, 0, 0, 0, 0, 1, 0, -1, 0, 0,    0);
    vec[1]  = mk(1, 1, 'hA1, 0, 0, 0, 0, 1, 0, -1, 0, 0,    0);
    vec[2]  = mk(1, 2, 'hA2, 0, 0, 0, 0, 1, 0, -1, 0, 0,    0);
    vec[3]  = mk(1, 3, 'hA3, 1, 0, 0, 0, 1, 1,  4, 0, 0,    0);
    vec[4]  = mk(0, 0, 0,    0, 1, 2, 0, 1, 1,  4, 1, 'hA2, 0);
    vec[5]  = mk(0, 0, 0,    0, 0, 0, 1, 1, 0, -1, 0, 0,    0);
    vec[6]  = mk(1, 0, 'hB0, 0, 0, 0, 0, 1, 0, -1, 0, 0,    0);
    vec[7]  = mk(1, 1, 'hB1, 1, 0, 0, 0, 1, 1,  2, 0, 0,    0);
    vec[8]  = mk(1, 4, 'hC4, 1, 0, 0, 0, 0, 1,  2, 0, 0,    0);
    vec[9]  = mk(0, 0, 0,    0, 1, 1, 1, 1, 1,  5, 1, 'hB1, 0);
    vec[10] = mk(0, 0, 0,    0, 1, 4, 0, 1, 1,  5, 1, 'hC4, 0);
    vec[11] = mk(0, 0, 0,    1, 0, 0, 0, 1, 1,  5, 0, 0,    0);
    vec[12] = mk(0, 0, 0,    0, 0, 0, 1, 1, 0, -1, 0, 0,    0);
    vec[13] = mk(0, 0, 0,    1, 0, 0, 0, 1, 0, -1, 0, 0,    0);

    do_reset("init");
    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      step(t, vec[i].we[0], vec[i].wa, DW'(vec[i].wd), vec[i].dn[0],
           vec[i].re[0], vec[i].ra, vec[i].rdn[0]);
      chk({t, "_tbl_mr"}, 64'(mem_ready), 64'(vec[i].mr));
      chk({t, "_tbl_v"}, 64'(rd_pkt_valid), 64'(vec[i].v));
      if (vec[i].len >= 0)
        chk({t, "_tbl_len"}, 64'(rd_pkt_len), 64'(vec[i].len));
      if (vec[i].rdc != 0)
        chk({t, "_tbl_rd"}, 64'(rd_data), 64'(vec[i].rd));
      chk({t, "_tbl_drop"}, 64'(drop_cnt), 64'(vec[i].drop));
    end

    // Both banks full: extra packet is dropped, stored packets intact
    do_reset("drop");
    for (int i = 0; i < 3; i++)
      step("d_a", 1, i, DW'(32'h30 + i), i == 2, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("d_b", 1, i, DW'(32'h40 + i), i == 2, 0, 0, 0);
    chk("drop_full_mr", 64'(mem_ready), 64'd0);
    for (int i = 0; i < 3; i++)
      step("d_x", 1, i, DW'(32'hDEAD), 0, 0, 0, 0);
    step("d_done", 0, 0, 0, 1, 0, 0, 0);
    chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
    chk("drop_len_a", 64'(rd_pkt_len), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step("d_rda", 0, 0, 0, 0, 1, i, 0);
      chk($sformatf("drop_rd_a%0d", i), 64'(rd_data), 64'(32'h30 + i));
    end
    step("d_rel", 0, 0, 0, 0, 0, 0, 1);
    step("d_rdb", 0, 0, 0, 0, 1, 1, 0);
    chk("drop_rd_b1", 64'(rd_data), 64'h41);

    // Full-bank length and counter saturation
    do_reset("sat");
    step("s_big", 1, DEP - 1, DW'(32'h5A5), 1, 0, 0, 0);
    chk("sat_len_full", 64'(rd_pkt_len), 64'(DEP));
    step("s_rel", 0, 0, 0, 0, 0, 0, 1);
    step("s_p1", 1, 0, DW'(1), 1, 0, 0, 0);
    step("s_p2", 1, 0, DW'(2), 1, 0, 0, 0);
    for (int i = 0; i < CMAX + 2; i++)
      step("s_drop", 1, 0, 0, 1, 0, 0, 0);
    chk("sat_cnt_max", 64'(drop_cnt), 64'(CMAX));

    // Reset while a packet is ready and another is half written
    do_reset("mid0");
    step("m_p1", 1, 0, DW'(32'h11), 1, 0, 0, 0);
    step("m_w0", 1, 0, DW'(32'h20), 0, 0, 0, 0);
    step("m_w1", 1, 1, DW'(32'h21), 0, 0, 0, 0);
    do_reset("mid");
    step("m_new", 1, 0, DW'(32'h77), 1, 0, 0, 0);
    chk("mid_len1", 64'(rd_pkt_len), 64'd1);
    step("m_rd", 0, 0, 0, 0, 1, 0, 0);
    chk("mid_rd", 64'(rd_data), 64'h77);

    // Random traffic against the model
    do_reset("rnd");
    for (int c = 0; c < 3000; c++) begin
      r_we  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      r_wa  = ($urandom_range(0, 31) == 0) ? DEP - 1
                                           : int'($urandom_range(0, 7));
      r_dn  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r_re  = $urandom_range(0, 1);
      r_ra  = $urandom_range(0, 7);
      r_rdn = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step("rnd", r_we[0], r_wa, DW'($urandom), r_dn[0],
           r_re[0], r_ra, r_rdn[0]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
